// File: rtl/dialog_text_ctrl.sv
// Dialog box text sequencer: loads a glyph string, reveals it at a frame-paced rate,
// and maps each pixel to the glyph cell and font-sheet offset for the sprite renderer.
module dialog_text_ctrl #(
  parameter int COLS          = 18,
  parameter int LINES         = 2,
  parameter int REVEAL_FRAMES = 2
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_in,
  input  logic [10:0] box_x_in,
  input  logic [9:0]  box_y_in,
  input  logic        char_valid_in,
  input  logic [7:0]  char_in,
  output logic        char_ready_out,
  input  logic        advance_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [9:0]  sprite_sel_x_out,
  output logic [8:0]  sprite_sel_y_out,
  output logic        active_out,
  output logic        busy_out,
  output logic        waiting_out
);

  localparam int MAX_CHARS = COLS * LINES;
  localparam int IDX_W     = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int CNT_W     = $clog2(MAX_CHARS + 1);
  localparam int FD_W      = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CHARS);
  localparam logic [FD_W-1:0]  FD_LAST  = FD_W'(REVEAL_FRAMES - 1);
  localparam logic [10:0]      BOX_W_PX = 11'(COLS * 8);
  localparam logic [10:0]      BOX_H_PX = 11'(LINES * 16);

  typedef enum logic [1:0] {IDLE, LOAD, REVEAL, WAIT} state_t;

  state_t           state, state_nxt;
  logic [10:0]      box_x, box_x_nxt;
  logic [9:0]       box_y, box_y_nxt;
  logic [CNT_W-1:0] wr_idx, wr_idx_nxt;
  logic [CNT_W-1:0] len, len_nxt;
  logic [CNT_W-1:0] shown_cnt, shown_nxt;
  logic [FD_W-1:0]  frame_div, frame_div_nxt;
  logic             buf_we;
  logic             frame_tick;

  logic [7:0] text_buf [MAX_CHARS];

  assign frame_tick  = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign busy_out    = (state != IDLE);
  assign waiting_out = (state == WAIT);

  always_comb begin
    state_nxt     = state;
    box_x_nxt     = box_x;
    box_y_nxt     = box_y;
    wr_idx_nxt    = wr_idx;
    len_nxt       = len;
    shown_nxt     = shown_cnt;
    frame_div_nxt = frame_div;
    buf_we        = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          box_x_nxt     = box_x_in;
          box_y_nxt     = box_y_in;
          wr_idx_nxt    = '0;
          len_nxt       = '0;
          shown_nxt     = '0;
          frame_div_nxt = '0;
          state_nxt     = LOAD;
        end
      end
      LOAD: begin
        if (char_valid_in && char_ready_out) begin
          if (char_in == 8'd0) begin
            len_nxt   = wr_idx;
            state_nxt = REVEAL;
          end else begin
            buf_we     = 1'b1;
            wr_idx_nxt = wr_idx + 1'b1;
            // Last slot filled: close the string so no overflow write can follow.
            if (wr_idx == MAX_CNT - 1'b1) begin
              len_nxt   = MAX_CNT;
              state_nxt = REVEAL;
            end
          end
        end
      end
      REVEAL: begin
        if (advance_in) begin
          shown_nxt = len;
          state_nxt = WAIT;
        end else if (shown_cnt == len) begin
          state_nxt = WAIT;
        end else if (frame_tick) begin
          if (frame_div == FD_LAST) begin
            frame_div_nxt = '0;
            shown_nxt     = shown_cnt + 1'b1;
          end else begin
            frame_div_nxt = frame_div + 1'b1;
          end
        end
      end
      WAIT: begin
        if (advance_in) begin
          shown_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      box_x          <= '0;
      box_y          <= '0;
      wr_idx         <= '0;
      len            <= '0;
      shown_cnt      <= '0;
      frame_div      <= '0;
      char_ready_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      box_x          <= box_x_nxt;
      box_y          <= box_y_nxt;
      wr_idx         <= wr_idx_nxt;
      len            <= len_nxt;
      shown_cnt      <= shown_nxt;
      frame_div      <= frame_div_nxt;
      char_ready_out <= (state_nxt == LOAD);
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in && buf_we) begin
      text_buf[wr_idx[IDX_W-1:0]] <= char_in;
    end
  end

  // Pixel path: locate the glyph cell under the current pixel.
  logic [10:0] rel_x, rel_y;
  logic [10:0] cell_idx;
  logic        in_box, hit;
  logic [7:0]  code, glyph;
  logic [10:0] x_pix;
  logic [9:0]  y_pix;
  logic [9:0]  sel_x;
  logic [8:0]  sel_y;

  always_comb begin
    rel_x    = hcount_in - box_x;
    rel_y    = {1'b0, vcount_in} - {1'b0, box_y};
    in_box   = (hcount_in >= box_x) && (vcount_in >= box_y) &&
               (rel_x < BOX_W_PX) && (rel_y < BOX_H_PX) && !rel_y[3];
    cell_idx = 11'(rel_y[10:4]) * 11'(COLS) + 11'(rel_x[10:3]);
    hit      = in_box && (cell_idx < 11'(shown_cnt));
    code     = hit ? text_buf[cell_idx[IDX_W-1:0]] : 8'd0;
    glyph    = (code >= 8'd160) ? 8'd0 : code;
    sel_x    = 10'(glyph[3:0]) * 10'd9;
    sel_y    = 9'(glyph[7:4]) * 9'd9;
    x_pix    = box_x + {rel_x[10:3], 3'b000};
    y_pix    = box_y + {rel_y[9:4], 4'b0000};
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      active_out       <= 1'b0;
      x_out            <= '0;
      y_out            <= '0;
      sprite_sel_x_out <= '0;
      sprite_sel_y_out <= '0;
    end else if (hit) begin
      active_out       <= 1'b1;
      x_out            <= x_pix;
      y_out            <= y_pix;
      sprite_sel_x_out <= sel_x;
      sprite_sel_y_out <= sel_y;
    end else begin
      active_out       <= 1'b0;
      x_out            <= box_x;
      y_out            <= box_y;
      sprite_sel_x_out <= '0;
      sprite_sel_y_out <= '0;
    end
  end

endmodule

// File: tb/tb_dialog_text_ctrl.sv
// Self-checking bench for dialog_text_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a reference model.
module tb_dialog_text_ctrl;

  localparam int COLS  = 18;
  localparam int LINES = 2;
  localparam int RF    = 2;
  localparam int MAXC  = COLS * LINES;
  localparam int PARK_H = 2000;
  localparam int PARK_V = 1000;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        start_in = 1'b0;
  logic [10:0] box_x_in = '0;
  logic [9:0]  box_y_in = '0;
  logic        char_valid_in = 1'b0;
  logic [7:0]  char_in = '0;
  logic        char_ready_out;
  logic        advance_in = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [9:0]  sprite_sel_x_out;
  logic [8:0]  sprite_sel_y_out;
  logic        active_out, busy_out, waiting_out;

  always #5 clk = ~clk;

  dialog_text_ctrl #(.COLS(COLS), .LINES(LINES), .REVEAL_FRAMES(RF)) dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .start_in        (start_in),
    .box_x_in        (box_x_in),
    .box_y_in        (box_y_in),
    .char_valid_in   (char_valid_in),
    .char_in         (char_in),
    .char_ready_out  (char_ready_out),
    .advance_in      (advance_in),
    .x_out           (x_out),
    .y_out           (y_out),
    .sprite_sel_x_out(sprite_sel_x_out),
    .sprite_sel_y_out(sprite_sel_y_out),
    .active_out      (active_out),
    .busy_out        (busy_out),
    .waiting_out     (waiting_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: dialog phase, string contents, reveal count derived from frame ticks.
  typedef enum {M_IDLE, M_LOAD, M_REVEAL, M_WAIT} phase_t;
  phase_t     m_ph = M_IDLE;
  int         m_bx = 0, m_by = 0, m_shown = 0, m_ticks = 0;
  logic [7:0] m_text[$];
  bit         m_ready = 0;
  bit         m_live = 0;
  int         e_act = 0, e_x = 0, e_y = 0, e_sx = 0, e_sy = 0;

  function automatic void pixel_expect(input int h, input int v);
    int rx, ry, col, line, idx, code;
    bit in_cell;
    rx = h - m_bx;
    ry = v - m_by;
    in_cell = (h >= m_bx) && (v >= m_by) && (rx < COLS * 8) && (ry < LINES * 16) && ((ry % 16) < 8);
    col  = rx / 8;
    line = ry / 16;
    idx  = line * COLS + col;
    if (in_cell && idx < m_shown) begin
      code  = m_text[idx];
      if (code >= 160) code = 0;
      e_act = 1;
      e_x   = (m_bx + col * 8) % 2048;
      e_y   = (m_by + line * 16) % 1024;
      e_sx  = (code % 16) * 9;
      e_sy  = (code / 16) * 9;
    end else begin
      e_act = 0;
      e_x   = m_bx;
      e_y   = m_by;
      e_sx  = 0;
      e_sy  = 0;
    end
  endfunction

  always @(posedge clk) begin
    if (rst_in) begin
      m_ph = M_IDLE; m_bx = 0; m_by = 0; m_shown = 0; m_ticks = 0;
      m_text.delete();
      e_act = 0; e_x = 0; e_y = 0; e_sx = 0; e_sy = 0;
    end else begin
      pixel_expect(int'(hcount_in), int'(vcount_in));
      case (m_ph)
        M_IDLE: if (start_in) begin
          m_bx = box_x_in; m_by = box_y_in;
          m_text.delete(); m_shown = 0; m_ticks = 0;
          m_ph = M_LOAD;
        end
        M_LOAD: if (char_valid_in && m_ready) begin
          if (char_in == 8'd0) m_ph = M_REVEAL;
          else begin
            m_text.push_back(char_in);
            if (m_text.size() == MAXC) m_ph = M_REVEAL;
          end
        end
        M_REVEAL: begin
          if (advance_in) begin
            m_shown = m_text.size(); m_ph = M_WAIT;
          end else if (m_shown == m_text.size()) m_ph = M_WAIT;
          else if (hcount_in == 0 && vcount_in == 0) begin
            m_ticks++;
            m_shown = m_ticks / RF;
          end
        end
        M_WAIT: if (advance_in) begin
          m_shown = 0; m_ph = M_IDLE;
        end
        default: m_ph = M_IDLE;
      endcase
    end
    m_ready = (m_ph == M_LOAD);
    m_live = 1;
  end

  always @(posedge clk) begin
    #1;
    if (m_live) begin
      chk("active", int'(active_out), e_act);
      chk("x", int'(x_out), e_x);
      chk("y", int'(y_out), e_y);
      chk("sel_x", int'(sprite_sel_x_out), e_sx);
      chk("sel_y", int'(sprite_sel_y_out), e_sy);
      chk("ready", int'(char_ready_out), int'(m_ready));
      chk("busy", int'(busy_out), int'(m_ph != M_IDLE));
      chk("waiting", int'(waiting_out), int'(m_ph == M_WAIT));
    end
  end

  task automatic drv(input bit s, input bit vld, input int c, input bit a, input int h, input int v);
    @(negedge clk);
    start_in = s; char_valid_in = vld; char_in = 8'(c); advance_in = a;
    hcount_in = 11'(h); vcount_in = 10'(v);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, PARK_H, PARK_V);
  endtask

  task automatic tick();
    drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic advance();
    drv(0, 0, 0, 1, PARK_H, PARK_V);
  endtask

  task automatic probe(input int h, input int v);
    drv(0, 0, 0, 0, h, v);
    @(posedge clk);
    #1;
  endtask

  task automatic start_dialog(input int bx, input int by);
    box_x_in = 11'(bx); box_y_in = 10'(by);
    drv(1, 0, 0, 0, PARK_H, PARK_V);
  endtask

  task automatic send(input int c);
    drv(0, 1, c, 0, PARK_H, PARK_V);
  endtask

  task automatic load_abc();
    start_dialog(40, 100);
    send(8'h23); send(8'h41); send(8'h42); send(8'h00);
  endtask

  initial begin
    int hs;
    int h, v;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_active", int'(active_out), 0);
    chk("rst_x", int'(x_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_ready", int'(char_ready_out), 0);
    @(negedge clk);
    rst_in = 1'b0;

    // Typewriter reveal, one glyph per two frame ticks
    load_abc();
    for (int k = 1; k <= 6; k++) begin
      tick(); idle(); idle();
      if (k == 5) chk("reveal_wait_tick5", int'(waiting_out), 0);
    end
    @(posedge clk); #1;
    chk("reveal_wait_tick6", int'(waiting_out), 1);
    probe(40, 100);
    chk("map0_active", int'(active_out), 1);
    chk("map0_x", int'(x_out), 40);
    chk("map0_y", int'(y_out), 100);
    chk("map0_sx", int'(sprite_sel_x_out), 27);
    chk("map0_sy", int'(sprite_sel_y_out), 18);
    probe(57, 101);
    chk("map2_x", int'(x_out), 56);
    chk("map2_sx", int'(sprite_sel_x_out), 18);
    chk("map2_sy", int'(sprite_sel_y_out), 36);
    probe(57, 109);
    chk("gap_active", int'(active_out), 0);
    chk("gap_x", int'(x_out), 40);
    advance(); idle();

    // Skip reveal, then close
    load_abc();
    tick(); idle(); tick(); idle();
    probe(48, 100);
    chk("skip_pre_active", int'(active_out), 0);
    advance();
    @(posedge clk); #1;
    chk("skip_waiting", int'(waiting_out), 1);
    probe(56, 100);
    chk("skip_all_shown", int'(active_out), 1);
    advance(); idle();
    probe(40, 100);
    chk("closed_active", int'(active_out), 0);
    chk("closed_busy", int'(busy_out), 0);

    // Full buffer: 40 offered, only MAX_CHARS taken
    start_dialog(200, 300);
    hs = 0;
    for (int i = 0; i < 40; i++) begin
      send(150 + i);
      if (char_ready_out) hs++;
    end
    idle();
    chk("full_accepted", hs, 36);
    chk("full_ready_low", int'(char_ready_out), 0);
    advance();
    probe(200, 316);
    chk("full_idx18_active", int'(active_out), 1);
    chk("full_idx18_x", int'(x_out), 200);
    chk("full_idx18_y", int'(y_out), 316);
    chk("full_idx18_sx", int'(sprite_sel_x_out), 0);
    probe(240, 300);
    chk("full_idx5_sx", int'(sprite_sel_x_out), 99);
    chk("full_idx5_sy", int'(sprite_sel_y_out), 81);
    advance(); idle();

    // Empty string
    start_dialog(10, 10);
    send(0);
    idle();
    @(posedge clk); #1;
    chk("empty_wait", int'(waiting_out), 1);
    advance(); idle();

    // Reset mid-reveal, then start ignored during LOAD
    load_abc();
    tick(); idle(); tick(); idle(); tick(); idle(); tick(); idle();
    probe(48, 100);
    chk("mid_shown2", int'(active_out), 1);
    idle();
    rst_in = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_active", int'(active_out), 0);
    chk("mid_rst_x", int'(x_out), 0);
    chk("mid_rst_y", int'(y_out), 0);
    chk("mid_rst_busy", int'(busy_out), 0);
    chk("mid_rst_wait", int'(waiting_out), 0);
    @(negedge clk);
    rst_in = 1'b0;
    start_dialog(40, 100);
    send(8'h41);
    box_x_in = 11'd300; box_y_in = 10'd300;
    drv(1, 1, 8'h42, 0, PARK_H, PARK_V);
    send(0);
    advance();
    probe(40, 100);
    chk("ld_start_x", int'(x_out), 40);
    chk("ld_start_sx", int'(sprite_sel_x_out), 9);
    chk("ld_start_sy", int'(sprite_sel_y_out), 36);
    probe(48, 100);
    chk("ld_start_idx1", int'(sprite_sel_x_out), 18);
    advance(); idle();

    // Randomized traffic
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      rst_in        = ($urandom_range(0, 2999) == 0);
      start_in      = ($urandom_range(0, 15) == 0);
      box_x_in      = 11'($urandom_range(0, 1880));
      box_y_in      = 10'($urandom_range(0, 980));
      char_valid_in = ($urandom_range(0, 9) < 7);
      char_in       = ($urandom_range(0, 14) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      advance_in    = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 4) == 0) begin
        h = 0; v = 0;
      end else begin
        h = m_bx + int'($urandom_range(0, 159)) - 8;
        v = m_by + int'($urandom_range(0, 39)) - 4;
        if (h < 0) h = 0;
        if (h > 2047) h = 2047;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
      end
      hcount_in = 11'(h);
      vcount_in = 10'(v);
    end
    @(negedge clk);
    rst_in = 1'b0; start_in = 0; char_valid_in = 0; advance_in = 0;
    repeat (3) idle();
    @(posedge clk); #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
